eq_lockstep_ctrl: RTL and testbench

- Scheduler and scoreboard for ILA-vs-HLS equivalence runs.
- Generates per-side step enables that gate the ILA model and the HLS target.
- Captures each side's arg_0 output tokens into per-side FIFOs and compares them in order.
- Manages completion, pipeline drain window and timeout, then reports pass/fail.
- Sits in the equivalence wrapper, between the shared stimulus and the two design instances.

---
 rtl/eq_ctrl_pkg.sv | 19 +
 rtl/eq_tok_fifo.sv | 46 ++++
 rtl/eq_lockstep_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_eq_lockstep_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_ctrl_pkg.sv
// Shared types and default sizing for the ILA-vs-HLS lockstep controller.
package eq_ctrl_pkg;

  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_DEPTH        = 4;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_DRAIN_CYCLES = 10;
  localparam int unsigned DEF_TIMEOUT      = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_PASS  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

endpackage

// File: rtl/eq_tok_fifo.sv
// Small synchronous token FIFO; dout always shows the head entry.
module eq_tok_fifo
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/eq_lockstep_ctrl.sv
// Lockstep scheduler and token scoreboard for ILA-vs-HLS equivalence runs.
module eq_lockstep_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              arg_0_TREADY,
  input  logic [DATA_W-1:0] ila_arg_0_TDATA,
  input  logic              ila_arg_0_TVALID,
  input  logic [DATA_W-1:0] hls_arg_0_TDATA,
  input  logic              hls_arg_0_TVALID,
  input  logic              ila_complete,
  input  logic              hls_complete,
  output logic              ila_step_en,
  output logic              hls_step_en,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              mismatch,
  output logic              timeout,
  output logic [CNT_W-1:0]  ila_tok_cnt,
  output logic [CNT_W-1:0]  hls_tok_cnt
);

  state_t            state;
  state_t            state_next;
  logic              ila_done;
  logic              hls_done;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  drain_cnt;
  logic              ila_full;
  logic              ila_empty;
  logic              hls_full;
  logic              hls_empty;
  logic [DATA_W-1:0] ila_head;
  logic [DATA_W-1:0] hls_head;
  logic              in_run;
  logic              in_drain;
  logic              cmp_active;
  logic              ila_push;
  logic              hls_push;
  logic              cmp_pop;
  logic              cmp_bad;
  logic              both_done;
  logic              run_clear;
  logic              set_pass;
  logic              set_fail;
  logic              set_mismatch;
  logic              set_timeout;

  assign in_run     = (state == ST_RUN);
  assign in_drain   = (state == ST_DRAIN);
  assign cmp_active = in_run || in_drain || (state == ST_CHECK);
  assign busy       = in_run || in_drain;

  // Step enables drop with rst so both models freeze in the reset cycle.
  assign ila_step_en = ~rst & in_run & ~ila_done & ~ila_complete & ~ila_full;
  assign hls_step_en = ~rst & ((in_run & ~hls_done & ~hls_complete) | in_drain) & ~hls_full;

  assign ila_push  = ila_step_en & ila_arg_0_TVALID & arg_0_TREADY;
  assign hls_push  = hls_step_en & hls_arg_0_TVALID & arg_0_TREADY;
  assign cmp_pop   = cmp_active & ~ila_empty & ~hls_empty;
  assign cmp_bad   = cmp_pop & (ila_head != hls_head);
  assign both_done = (ila_done | ila_complete) & (hls_done | hls_complete);

  eq_tok_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ila_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (run_clear),
    .push  (ila_push),
    .pop   (cmp_pop),
    .din   (ila_arg_0_TDATA),
    .dout  (ila_head),
    .full  (ila_full),
    .empty (ila_empty)
  );

  eq_tok_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_hls_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (run_clear),
    .push  (hls_push),
    .pop   (cmp_pop),
    .din   (hls_arg_0_TDATA),
    .dout  (hls_head),
    .full  (hls_full),
    .empty (hls_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and run-control decode; a data mismatch outranks every other exit.
  always_comb begin
    state_next   = state;
    run_clear    = 1'b0;
    set_pass     = 1'b0;
    set_fail     = 1'b0;
    set_mismatch = 1'b0;
    set_timeout  = 1'b0;
    case (state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_next = ST_RUN;
          run_clear  = 1'b1;
        end
      end
      ST_RUN: begin
        if (cmp_bad) begin
          state_next   = ST_FAIL;
          set_fail     = 1'b1;
          set_mismatch = 1'b1;
        end else if (both_done) begin
          state_next = ST_DRAIN;
        end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_next  = ST_FAIL;
          set_fail    = 1'b1;
          set_timeout = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cmp_bad) begin
          state_next   = ST_FAIL;
          set_fail     = 1'b1;
          set_mismatch = 1'b1;
        end else if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Paired pops keep at most one entry on the shorter side, so with equal
        // token counts a clean compare this cycle leaves both FIFOs empty.
        if (cmp_bad) begin
          state_next   = ST_FAIL;
          set_fail     = 1'b1;
          set_mismatch = 1'b1;
        end else if ((ila_tok_cnt == hls_tok_cnt) && (ila_empty == hls_empty)) begin
          state_next = ST_PASS;
          set_pass   = 1'b1;
        end else begin
          state_next = ST_FAIL;
          set_fail   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Run bookkeeping: done latches, cycle/token counters and sticky result flags.
  always_ff @(posedge clk) begin
    if (rst || run_clear) begin
      ila_done    <= 1'b0;
      hls_done    <= 1'b0;
      run_cnt     <= '0;
      drain_cnt   <= '0;
      ila_tok_cnt <= '0;
      hls_tok_cnt <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (in_run) begin
        ila_done <= ila_done | ila_complete;
        hls_done <= hls_done | hls_complete;
        run_cnt  <= run_cnt + CNT_W'(1);
      end
      if (in_drain) drain_cnt <= drain_cnt + CNT_W'(1);
      if (ila_push && (ila_tok_cnt != '1)) ila_tok_cnt <= ila_tok_cnt + CNT_W'(1);
      if (hls_push && (hls_tok_cnt != '1)) hls_tok_cnt <= hls_tok_cnt + CNT_W'(1);
      if (set_pass)     pass     <= 1'b1;
      if (set_fail)     fail     <= 1'b1;
      if (set_mismatch) mismatch <= 1'b1;
      if (set_timeout)  timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eq_lockstep_ctrl.sv
// Bench for eq_lockstep_ctrl: directed test-plan runs plus randomized runs vs a queue model.
module tb_eq_lockstep_ctrl;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned DRAIN_CYCLES = 10;
  localparam int unsigned TIMEOUT      = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              arg_0_TREADY;
  logic [DATA_W-1:0] ila_arg_0_TDATA;
  logic              ila_arg_0_TVALID;
  logic [DATA_W-1:0] hls_arg_0_TDATA;
  logic              hls_arg_0_TVALID;
  logic              ila_complete;
  logic              hls_complete;
  logic              ila_step_en;
  logic              hls_step_en;
  logic              busy;
  logic              pass;
  logic              fail;
  logic              mismatch;
  logic              timeout;
  logic [CNT_W-1:0]  ila_tok_cnt;
  logic [CNT_W-1:0]  hls_tok_cnt;

  always #5 clk = ~clk;

  eq_lockstep_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
    .DRAIN_CYCLES(DRAIN_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .arg_0_TREADY(arg_0_TREADY),
    .ila_arg_0_TDATA(ila_arg_0_TDATA), .ila_arg_0_TVALID(ila_arg_0_TVALID),
    .hls_arg_0_TDATA(hls_arg_0_TDATA), .hls_arg_0_TVALID(hls_arg_0_TVALID),
    .ila_complete(ila_complete), .hls_complete(hls_complete),
    .ila_step_en(ila_step_en), .hls_step_en(hls_step_en), .busy(busy),
    .pass(pass), .fail(fail), .mismatch(mismatch), .timeout(timeout),
    .ila_tok_cnt(ila_tok_cnt), .hls_tok_cnt(hls_tok_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 = waiting/result, 1 = stepping, 2 = drain window, 3 = final check
  int         ph;
  bit         m_pass, m_fail, m_mis, m_to, m_idone, m_hdone;
  int         m_icnt, m_hcnt, m_rcyc, m_dcyc;
  logic [7:0] qi[$];
  logic [7:0] qh[$];

  // Token sources: token k becomes offered at cycle *_at[k] and stays offered until captured
  logic [7:0] si_dat[$];
  logic [7:0] sh_dat[$];
  int         si_at[$];
  int         sh_at[$];
  int         si_idx, sh_idx, ci_at, ch_at, rdy_pct, cyc;
  bit         ci_wait, ch_wait;

  typedef struct { int cyc; int sel; bit val; } probe_t;
  probe_t probes[$];

  task automatic model_reset();
    ph = 0; m_pass = 0; m_fail = 0; m_mis = 0; m_to = 0; m_idone = 0; m_hdone = 0;
    m_icnt = 0; m_hcnt = 0; m_rcyc = 0; m_dcyc = 0;
    qi.delete(); qh.delete();
  endtask

  task automatic clr_src();
    si_dat.delete(); sh_dat.delete(); si_at.delete(); sh_at.delete(); probes.delete();
    ci_at = 0; ch_at = 0; ci_wait = 1; ch_wait = 1; rdy_pct = 100;
  endtask

  task automatic add_i(input logic [7:0] d, input int at);
    si_dat.push_back(d); si_at.push_back(at);
  endtask

  task automatic add_h(input logic [7:0] d, input int at);
    sh_dat.push_back(d); sh_at.push_back(at);
  endtask

  task automatic add_probe(input int c, input int sel, input bit v);
    probe_t p;
    p.cyc = c; p.sel = sel; p.val = v;
    probes.push_back(p);
  endtask

  // One clock: drive inputs, compare DUT with model, then advance the model
  task automatic cycle_step(input bit r, input bit s, input string tag);
    bit iv, hv, ic, hc, ie, he, ip, hp, bad, got;
    logic [7:0] a, b;
    @(posedge clk); #1;
    iv = (si_idx < si_dat.size()) && (cyc >= si_at[si_idx]);
    hv = (sh_idx < sh_dat.size()) && (cyc >= sh_at[sh_idx]);
    ic = (cyc >= ci_at) && (!ci_wait || si_idx == si_dat.size());
    hc = (cyc >= ch_at) && (!ch_wait || sh_idx == sh_dat.size());
    ila_arg_0_TVALID = iv;
    ila_arg_0_TDATA  = iv ? si_dat[si_idx] : 8'($urandom);
    hls_arg_0_TVALID = hv;
    hls_arg_0_TDATA  = hv ? sh_dat[sh_idx] : 8'($urandom);
    ila_complete     = ic;
    hls_complete     = hc;
    arg_0_TREADY     = ($urandom_range(99) < rdy_pct);
    rst   = r;
    start = s;
    #1;
    ie = !r && ph == 1 && !m_idone && !ic && qi.size() < DEPTH;
    he = !r && ((ph == 1 && !m_hdone && !hc) || ph == 2) && qh.size() < DEPTH;
    check({tag, "_ila_en"},   32'(ila_step_en), 32'(ie));
    check({tag, "_hls_en"},   32'(hls_step_en), 32'(he));
    check({tag, "_busy"},     32'(busy),        32'(ph == 1 || ph == 2));
    check({tag, "_pass"},     32'(pass),        32'(m_pass));
    check({tag, "_fail"},     32'(fail),        32'(m_fail));
    check({tag, "_mismatch"}, 32'(mismatch),    32'(m_mis));
    check({tag, "_timeout"},  32'(timeout),     32'(m_to));
    check({tag, "_ila_cnt"},  32'(ila_tok_cnt), 32'(m_icnt));
    check({tag, "_hls_cnt"},  32'(hls_tok_cnt), 32'(m_hcnt));
    foreach (probes[i]) begin
      if (probes[i].cyc == cyc) begin
        case (probes[i].sel)
          0:       got = ila_step_en;
          1:       got = fail;
          2:       got = timeout;
          3:       got = busy;
          default: got = hls_step_en;
        endcase
        check($sformatf("%s_probe%0d", tag, i), 32'(got), 32'(probes[i].val));
      end
    end
    ip = ie && iv && arg_0_TREADY;
    hp = he && hv && arg_0_TREADY;
    if (ip) si_idx++;
    if (hp) sh_idx++;
    if (r) begin
      model_reset();
    end else if (ph == 0) begin
      if (s) begin
        model_reset();
        ph = 1;
      end
    end else begin
      bad = 0;
      if (qi.size() > 0 && qh.size() > 0) begin
        a = qi.pop_front();
        b = qh.pop_front();
        bad = (a != b);
      end
      if (ip) begin qi.push_back(ila_arg_0_TDATA); m_icnt++; end
      if (hp) begin qh.push_back(hls_arg_0_TDATA); m_hcnt++; end
      if (bad) begin
        ph = 0; m_fail = 1; m_mis = 1;
      end else if (ph == 1) begin
        if ((m_idone || ic) && (m_hdone || hc)) begin
          ph = 2; m_dcyc = 0;
        end else if (m_rcyc == TIMEOUT - 1) begin
          ph = 0; m_fail = 1; m_to = 1;
        end
        m_idone = m_idone || ic;
        m_hdone = m_hdone || hc;
        m_rcyc++;
      end else if (ph == 2) begin
        m_dcyc++;
        if (m_dcyc == DRAIN_CYCLES) ph = 3;
      end else begin
        ph = 0;
        if (m_icnt == m_hcnt && qi.size() == 0 && qh.size() == 0) m_pass = 1;
        else m_fail = 1;
      end
    end
    cyc++;
  endtask

  task automatic run_scen(input string tag, input int rst_at, input int dup_at);
    bit r, s;
    si_idx = 0; sh_idx = 0; cyc = -1;
    cycle_step(1'b0, 1'b1, tag);
    for (int k = 0; k < 200; k++) begin
      r = (cyc == rst_at);
      s = (cyc == dup_at);
      cycle_step(r, s, tag);
      if (r) begin
        cycle_step(1'b0, 1'b0, tag);
        check({tag, "_rst_busy"}, 32'(busy), 32'(0));
        check({tag, "_rst_cnt"},  32'(ila_tok_cnt), 32'(0));
        check({tag, "_rst_pass"}, 32'(pass), 32'(0));
        return;
      end
      if (ph == 0) begin
        cycle_step(1'b0, 1'b0, tag);
        return;
      end
    end
    check({tag, "_budget"}, 32'(ph), 32'(0));
  endtask

  task automatic setup_match();
    clr_src();
    add_i(8'h11, 0); add_i(8'h22, 1); add_i(8'h33, 2);
    add_h(8'h11, 0); add_h(8'h22, 1); add_h(8'h33, 2);
  endtask

  initial begin
    int n, t_i, t_h, j;
    logic [7:0] d;
    rst = 1; start = 0; arg_0_TREADY = 0;
    ila_arg_0_TVALID = 0; ila_arg_0_TDATA = '0; hls_arg_0_TVALID = 0; hls_arg_0_TDATA = '0;
    ila_complete = 0; hls_complete = 0;
    repeat (3) @(posedge clk);
    model_reset();
    clr_src();
    si_idx = 0; sh_idx = 0; cyc = -1;
    cycle_step(1'b1, 1'b0, "reset");
    cycle_step(1'b0, 1'b0, "idle");

    setup_match();
    run_scen("match", -1, -1);
    check("match_pass", 32'(pass), 32'(1));
    check("match_fail", 32'(fail), 32'(0));
    check("match_icnt", 32'(ila_tok_cnt), 32'(3));
    check("match_hcnt", 32'(hls_tok_cnt), 32'(3));

    clr_src();
    add_i(8'h11, 0); add_i(8'h23, 1); add_i(8'h33, 2);
    add_h(8'h11, 0); add_h(8'h22, 1); add_h(8'h33, 2);
    run_scen("mism", -1, -1);
    check("mism_fail", 32'(fail), 32'(1));
    check("mism_flag", 32'(mismatch), 32'(1));
    check("mism_en", 32'({ila_step_en, hls_step_en}), 32'(0));

    clr_src();
    for (int k = 0; k < 6; k++) begin
      add_i(8'(8'h40 + k), 0);
      add_h(8'(8'h40 + k), 20);
    end
    add_probe(10, 0, 1'b0);
    add_probe(22, 0, 1'b1);
    run_scen("skew", -1, -1);
    check("skew_pass", 32'(pass), 32'(1));

    setup_match();
    sh_at[2] = 9; ch_at = 3; ch_wait = 0;
    run_scen("late6", -1, -1);
    check("late6_pass", 32'(pass), 32'(1));
    check("late6_hcnt", 32'(hls_tok_cnt), 32'(3));

    setup_match();
    sh_at[2] = 15; ch_at = 3; ch_wait = 0;
    run_scen("late12", -1, -1);
    check("late12_fail", 32'(fail), 32'(1));
    check("late12_mism", 32'(mismatch), 32'(0));

    clr_src();
    ci_at = 100000;
    add_probe(63, 1, 1'b0);
    add_probe(64, 1, 1'b1);
    add_probe(64, 2, 1'b1);
    add_probe(64, 3, 1'b0);
    run_scen("tmo", -1, -1);
    check("tmo_flag", 32'(timeout), 32'(1));

    setup_match();
    run_scen("rstdrain", 6, -1);
    setup_match();
    run_scen("restart", -1, 2);
    check("restart_pass", 32'(pass), 32'(1));

    for (int it = 0; it < 24; it++) begin
      clr_src();
      n = $urandom_range(6, 1);
      t_i = 0;
      t_h = $urandom_range(8);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        t_i += $urandom_range(3);
        t_h += $urandom_range(4);
        add_i(d, t_i);
        add_h(d, t_h);
      end
      if ($urandom_range(3) == 0) begin
        j = $urandom_range(n - 1);
        sh_dat[j] = sh_dat[j] ^ (8'h01 << $urandom_range(7));
      end
      ci_at = $urandom_range(3);
      if ($urandom_range(4) == 0) begin
        ch_wait = 0;
        ch_at = t_h - $urandom_range(8);
        if (ch_at < 0) ch_at = 0;
      end
      rdy_pct = $urandom_range(100, 60);
      run_scen($sformatf("rnd%0d", it), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
